vram_copy_ctrl: RTL and testbench
=================================

// Module: vram_copy_ctrl
// PURPOSE
//  Sequences the back-to-front VRAM copy on the video card. When the CPU has set the copy enable
//  register (nonzero), a frame copy is armed at the next vertical-blank start.
//  The block then streams NBYTES bytes from back VRAM to front VRAM.
//  It drives copy_in_progress so the CPU-side VRAM port releases the back VRAM bus for the duration.
// PARAMETERS
//  NBYTES  4800  bytes copied per frame; addresses 0..NBYTES-1 (CPU window 0x8000-0x92BF)
//  AW      13    VRAM address width
//  RD_LAT  1     back VRAM read latency in cycles, from rd_low asserted to back_vram_q valid (>=1)
// PORTS
//  clk               in   1   system clock; all logic on rising edge
//  rst               in   1   asynchronous reset, active-high
//  copy_enable       in   8   CPU copy register; nonzero = copy on next vblank
//  vblank_start      in   1   one-cycle pulse at start of vertical blank
//  vblank            in   1   level, high during vertical blank
//  back_vram_rd_low  out  1   back VRAM read strobe, active-low
//  back_vram_addr    out  AW  back VRAM read address
//  back_vram_q       in   8   back VRAM read data
//  front_vram_wr_low out  1   front VRAM write strobe, active-low
//  front_vram_addr   out  AW  front VRAM write address
//  front_vram_data   out  8   front VRAM write data
//  copy_in_progress  out  1   high while the copy owns back VRAM
//  copy_done         out  1   one-cycle pulse on normal completion
//  copy_aborted      out  1   one-cycle pulse on abort (VCOPY_ABORT_EN only)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, addr=0, back_vram_rd_low=1, front_vram_wr_low=1,
//    both addrs=0, front_vram_data=0, copy_in_progress=0, copy_done=0, copy_aborted=0.
//  - All outputs are registered.
//  - FSM states: IDLE, ARM, READ, WRITE, DONE.
//  - IDLE: when vblank_start=1 and copy_enable!=0 (sampled in the same cycle) -> ARM.
//    Otherwise stay in IDLE.
//  - ARM: exactly 1 cycle. copy_in_progress=1; no VRAM access. This is the guard cycle that lets
//    the registered CPU port drop its bus. -> READ with addr=0.
//  - READ: back_vram_rd_low=0, back_vram_addr=addr, held for RD_LAT cycles.
//    On the last cycle, capture back_vram_q. -> WRITE.
//  - WRITE: 1 cycle. front_vram_wr_low=0, front_vram_addr=addr, front_vram_data=captured byte;
//    back_vram_rd_low=1.
//    If addr==NBYTES-1 -> DONE. Else addr<=addr+1 -> READ.
//  - DONE: 1 cycle. copy_done=1; strobes high; copy_in_progress=0. -> IDLE.
//  - copy_in_progress is high in ARM, READ and WRITE only.
//  - Never low-assert rd_low and wr_low in the same cycle.
//  - Frame time = 2 + NBYTES*(RD_LAT+1) cycles, from the ARM cycle through the DONE cycle.
//    Default: 9602 cycles.
//  - addr is AW bits and never exceeds NBYTES-1; there is no wrap past the last byte.
//  - vblank_start while not in IDLE: ignored, with no queuing.
//  - copy_enable is sampled only in IDLE. Changes mid-copy are ignored.
//  - A simultaneous vblank_start and copy_enable change in IDLE uses the value present that cycle.
//  - copy_enable is level semantics: it is not self-clearing. The copy repeats every frame while
//    it is nonzero.
//  - rst mid-copy: strobes deassert asynchronously; the next copy restarts at addr 0.
//    The front buffer is partial until then.
// CONFIGURATION
//  - Macro VCOPY_ABORT_EN.
//  - Defined: vblank is sampled in READ/WRITE. If vblank==0 is seen, the current byte completes
//    through its WRITE. The FSM then goes to DONE with copy_aborted=1 and copy_done=0.
//    The next copy starts again from addr 0.
//  - Undefined: vblank is ignored after arming; the copy always runs to NBYTES.
//    copy_aborted is tied to 0.
// TESTING
//  1. copy_enable=0x01, pulse vblank_start, back VRAM preloaded with addr[7:0]
//     -> ARM at +1. Front VRAM equals back for all 4800 bytes.
//     copy_done pulses 9601 cycles after the ARM cycle.
//  2. copy_enable=0x00, pulse vblank_start
//     -> stays IDLE; rd_low/wr_low stay 1; copy_in_progress stays 0.
//  3. Extra vblank_start pulse at byte 100 with copy_enable set to 0 mid-copy
//     -> copy continues uninterrupted; exactly one copy_done.
//  4. rst high at byte 2000 for 1 cycle
//     -> strobes 1 and copy_in_progress 0 within the reset cycle.
//     The next vblank_start copies from addr 0.
//  5. RD_LAT=2, 8-byte NBYTES
//     -> each READ lasts 2 cycles; data is captured on the second cycle.
//     copy_done arrives 1+8*3 cycles after ARM.
//  6. VCOPY_ABORT_EN defined, vblank drops at byte 10
//     -> byte 10 is written; then copy_aborted=1 and no copy_done; front bytes 11+ are unchanged.

Source files
------------

// File: rtl/vram_copy_ctrl.sv
// vram_copy_ctrl: copies NBYTES from back VRAM to front VRAM, one copy per vblank while copy_enable is nonzero
// Ports: clk/rst (async, active-high); copy_enable, vblank_start, vblank from the CPU/video timing;
//   back_vram_rd_low/back_vram_addr/back_vram_q read side; front_vram_wr_low/front_vram_addr/front_vram_data
//   write side; copy_in_progress, copy_done, copy_aborted status. All outputs are registered.
// Macro VCOPY_ABORT_EN: when defined, vblank falling mid-copy ends the copy after the current byte.
module vram_copy_ctrl #(
  parameter int NBYTES = 4800,
  parameter int AW     = 13,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    copy_enable,
  input  logic          vblank_start,
  input  logic          vblank,
  output logic          back_vram_rd_low,
  output logic [AW-1:0] back_vram_addr,
  input  logic [7:0]    back_vram_q,
  output logic          front_vram_wr_low,
  output logic [AW-1:0] front_vram_addr,
  output logic [7:0]    front_vram_data,
  output logic          copy_in_progress,
  output logic          copy_done,
  output logic          copy_aborted
);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  typedef enum logic [2:0] {IDLE, ARM, READ, WRITE, DONE} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          rd_low_q, rd_low_d, wr_low_q, wr_low_d;
  logic          cip_q, cip_d, done_q, done_d, aborted_q, aborted_d;
  logic          abort_now;
`ifdef VCOPY_ABORT_EN
  logic abort_q;
  // sticky: once vblank is seen low, the byte in flight still finishes its WRITE
  assign abort_now = abort_q | ((state_q == READ || state_q == WRITE) & ~vblank);
  always_ff @(posedge clk or posedge rst)
    if (rst) abort_q <= 1'b0;
    else abort_q <= (state_q == ARM) ? 1'b0 : abort_now;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign abort_now = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: state_d = (vblank_start && copy_enable != 8'd0) ? ARM : IDLE;
      ARM: begin
        state_d = READ;
        addr_d  = '0;
        cnt_d   = '0;
      end
      READ:
        if (cnt_q == CW'(RD_LAT - 1)) begin
          state_d = WRITE;
          data_d  = back_vram_q;
        end else cnt_d = cnt_q + 1'b1;
      WRITE:
        if (abort_now || addr_q == AW'(NBYTES - 1)) state_d = DONE;
        else begin
          state_d = READ;
          addr_d  = addr_q + 1'b1;
          cnt_d   = '0;
        end
      default: state_d = IDLE;
    endcase
    // outputs follow the next state so they line up with the state register
    rd_low_d  = state_d != READ;
    wr_low_d  = state_d != WRITE;
    cip_d     = state_d == ARM || state_d == READ || state_d == WRITE;
    done_d    = state_d == DONE && !abort_now;
    aborted_d = state_d == DONE && abort_now;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      rd_low_q  <= 1'b1;
      wr_low_q  <= 1'b1;
      cip_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      rd_low_q  <= rd_low_d;
      wr_low_q  <= wr_low_d;
      cip_q     <= cip_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  assign back_vram_rd_low  = rd_low_q;
  assign back_vram_addr    = addr_q;
  assign front_vram_wr_low = wr_low_q;
  assign front_vram_addr   = addr_q;
  assign front_vram_data   = data_q;
  assign copy_in_progress  = cip_q;
  assign copy_done         = done_q;
  assign copy_aborted      = aborted_q;
endmodule

// File: tb/tb_vram_copy_ctrl.sv
// tb_vram_copy_ctrl: directed checks of vram_copy_ctrl (default 4800-byte instance plus an 8-byte RD_LAT=2 instance)
module tb_vram_copy_ctrl;
  logic        clk, rst, vblank_start, vblank;
  logic [7:0]  copy_enable, xr;
  logic        rd_low, wr_low, cip, done, aborted;
  logic [12:0] back_addr, front_addr;
  logic [7:0]  back_q, front_data;
  logic        rd_low2, wr_low2, cip2, done2, aborted2;
  logic [3:0]  back_addr2, front_addr2;
  logic [7:0]  back_q2, front_data2;
  logic [7:0]  front [0:4799];
  logic [7:0]  front2 [0:7];
  int run, run2, ndone, nabort, overlap, t, ncmp, nfail, at, bad, d0;
  logic r1, r2, w3;

  vram_copy_ctrl dut (
    .clk(clk), .rst(rst), .copy_enable(copy_enable), .vblank_start(vblank_start), .vblank(vblank),
    .back_vram_rd_low(rd_low), .back_vram_addr(back_addr), .back_vram_q(back_q),
    .front_vram_wr_low(wr_low), .front_vram_addr(front_addr), .front_vram_data(front_data),
    .copy_in_progress(cip), .copy_done(done), .copy_aborted(aborted));

  vram_copy_ctrl #(.NBYTES(8), .AW(4), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .copy_enable(copy_enable), .vblank_start(vblank_start), .vblank(vblank),
    .back_vram_rd_low(rd_low2), .back_vram_addr(back_addr2), .back_vram_q(back_q2),
    .front_vram_wr_low(wr_low2), .front_vram_addr(front_addr2), .front_vram_data(front_data2),
    .copy_in_progress(cip2), .copy_done(done2), .copy_aborted(aborted2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // back VRAM models: data is valid only on the RD_LAT-th cycle of a read strobe
  always @(posedge clk) begin
    run  <= rd_low ? 0 : run + 1;
    run2 <= rd_low2 ? 0 : run2 + 1;
    if (!wr_low) front[front_addr] <= front_data;
    if (!wr_low2) front2[front_addr2] <= front_data2;
  end
  assign back_q  = (!rd_low && run == 0) ? (back_addr[7:0] ^ xr) : 8'hEE;
  assign back_q2 = (!rd_low2 && run2 == 1) ? 8'({4'd0, back_addr2} * 3 + 1) : 8'hEE;

  always @(negedge clk) begin
    if (done) ndone <= ndone + 1;
    if (aborted) nabort <= nabort + 1;
    if (!rd_low && !wr_low) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic arm(input logic [7:0] en);
    copy_enable  = en;
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    t = 0;
  endtask

  task automatic wait_end(output int when);
    while (!(done || aborted) && t < 20000) step();
    when = t;
  endtask

  task automatic check_front(input string tag, input logic [7:0] lo, input int split, input logic [7:0] hi);
    int n;
    n = 0;
    for (int i = 0; i < 4800; i++)
      if (front[i] !== (8'(i) ^ ((i < split) ? lo : hi))) n++;
    chk(tag, n, 0);
  endtask

  initial begin
    ncmp = 0; nfail = 0; ndone = 0; nabort = 0; overlap = 0; run = 0; run2 = 0; t = 0;
    rst = 1'b1; copy_enable = 8'd0; vblank_start = 1'b0; vblank = 1'b1; xr = 8'h00;
    repeat (3) step();
    chk("rst_rd_low", rd_low, 1);
    chk("rst_wr_low", wr_low, 1);
    chk("rst_cip", cip, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_back_addr", back_addr, 0);
    chk("rst_front_addr", front_addr, 0);
    chk("rst_front_data", front_data, 0);
    rst = 1'b0;
    step();
    // copy_enable zero: vblank_start must not start anything
    arm(8'h00);
    bad = 0;
    repeat (6) begin
      if (cip || !rd_low || !wr_low || cip2) bad++;
      step();
    end
    chk("idle_no_enable", bad, 0);
    // full copy, plus the short RD_LAT=2 instance running alongside
    arm(8'h01);
    chk("arm_cip", cip, 1);
    chk("arm_rd_low", rd_low, 1);
    chk("arm_wr_low", wr_low, 1);
    d0 = ndone;
    r1 = 1'b1; r2 = 1'b1; w3 = 1'b1; at = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 1) r1 = rd_low2;
      if (i == 2) r2 = rd_low2;
      if (i == 3) w3 = wr_low2;
      if (done2 && at < 0) at = i;
    end
    chk("lat2_read_c1", r1, 0);
    chk("lat2_read_c2", r2, 0);
    chk("lat2_write_c3", w3, 0);
    chk("lat2_done_at", at, 25);
    bad = 0;
    for (int i = 0; i < 8; i++) if (front2[i] !== 8'(i * 3 + 1)) bad++;
    chk("lat2_front", bad, 0);
    wait_end(at);
    chk("t1_done_at", at, 9601);
    step();
    chk("t1_done_width", done, 0);
    chk("t1_cip_after", cip, 0);
    chk("t1_one_done", ndone - d0, 1);
    check_front("t1_front", 8'h00, 4800, 8'h00);
    // extra vblank_start mid-copy must be ignored and not queued
    xr = 8'h5A;
    arm(8'h01);
    d0 = ndone;
    while (t < 201) step();
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    wait_end(at);
    chk("t3_done_at", at, 9601);
    bad = 0;
    repeat (4) begin
      step();
      if (cip) bad++;
    end
    chk("t3_no_requeue", bad, 0);
    chk("t3_one_done", ndone - d0, 1);
    check_front("t3_front", 8'h5A, 4800, 8'h5A);
    // enable dropped mid-copy, then async reset at byte 2000
    xr = 8'hC3;
    arm(8'h01);
    copy_enable = 8'h00;
    while (t < 4001) step();
    chk("t4_reading", rd_low, 0);
    rst = 1'b1;
    #1;
    chk("t4_rst_rd_low", rd_low, 1);
    chk("t4_rst_wr_low", wr_low, 1);
    chk("t4_rst_cip", cip, 0);
    step();
    rst = 1'b0;
    step();
    check_front("t4_partial", 8'hC3, 2000, 8'h5A);
    xr = 8'h77;
    arm(8'h01);
    step();
    chk("t4_restart_addr", back_addr, 0);
    wait_end(at);
    chk("t4_done_at", at, 9601);
    step();
    check_front("t4_front", 8'h77, 4800, 8'h77);
    // vblank falls at byte 10
    xr = 8'h11;
    d0 = ndone;
    arm(8'h01);
    while (t < 21) step();
    vblank = 1'b0;
    wait_end(at);
`ifdef VCOPY_ABORT_EN
    chk("t6_abort_at", at, 23);
    chk("t6_aborted", aborted, 1);
    chk("t6_no_done", done, 0);
    step();
    chk("t6_done_count", ndone - d0, 0);
    check_front("t6_front", 8'h11, 11, 8'h77);
`else
    chk("t6_done_at", at, 9601);
    chk("t6_not_aborted", aborted, 0);
    step();
    chk("t6_done_count", ndone - d0, 1);
    check_front("t6_front", 8'h11, 4800, 8'h11);
    chk("t6_abort_count", nabort, 0);
`endif
    vblank = 1'b1;
    step();
    chk("strobe_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
